// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: reads 1-3 byte instructions from a byte-wide
// synchronous memory and presents them with their PC over valid/ready.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_strobe,
  input  logic [7:0]        mem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_op,
  output logic [7:0]        instr_b2,
  output logic [7:0]        instr_b3,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  typedef enum logic [2:0] {
    S_REQ,
    S_CAP1,
    S_CAP2,
    S_CAP3,
    S_HOLD
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              valid_q;
  logic [7:0]        op_q, b2_q, b3_q;
  logic [1:0]        len_q;
  logic [ADDR_W-1:0] pc_q;

  // Instruction length from the low opcode nibble.
  function automatic logic [1:0] decode_len(input logic [7:0] op);
    logic [1:0] len;
    casez (op[3:0])
      4'b111?:         len = 2'd1;
      4'b01??, 4'b1101: len = 2'd3;
      default:         len = 2'd2;
    endcase
    return len;
  endfunction

  // Read request and next fetch address; a redirect suppresses the read.
  always_comb begin
    mem_strobe = 1'b0;
    fetch_pc_d = fetch_pc_q;
    if (!reset && !redirect_valid) begin
      case (state_q)
        S_REQ:   mem_strobe = 1'b1;
        S_CAP1:  mem_strobe = (decode_len(mem_data) != 2'd1);
        S_CAP2:  mem_strobe = (len_q == 2'd3);
        S_HOLD:  mem_strobe = instr_ready;
        default: mem_strobe = 1'b0;
      endcase
    end
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (mem_strobe) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end
  end

  // Byte capture FSM with registered bundle outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      op_q       <= 8'h00;
      b2_q       <= 8'h00;
      b3_q       <= 8'h00;
      len_q      <= 2'd0;
      pc_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      if (redirect_valid) begin
        state_q <= S_REQ;
        valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_REQ: state_q <= S_CAP1;
          S_CAP1: begin
            op_q  <= mem_data;
            pc_q  <= fetch_pc_q - ADDR_W'(1);
            len_q <= decode_len(mem_data);
            b2_q  <= 8'h00;
            b3_q  <= 8'h00;
            if (decode_len(mem_data) == 2'd1) begin
              valid_q <= 1'b1;
              state_q <= S_HOLD;
            end else begin
              state_q <= S_CAP2;
            end
          end
          S_CAP2: begin
            b2_q <= mem_data;
            if (len_q == 2'd2) begin
              valid_q <= 1'b1;
              state_q <= S_HOLD;
            end else begin
              state_q <= S_CAP3;
            end
          end
          S_CAP3: begin
            b3_q    <= mem_data;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end
          S_HOLD: begin
            if (instr_ready) begin
              valid_q <= 1'b0;
              state_q <= S_CAP1;
            end
          end
          default: state_q <= S_REQ;
        endcase
      end
    end
  end

  assign mem_addr    = fetch_pc_q;
  assign instr_valid = valid_q;
  assign instr_op    = op_q;
  assign instr_b2    = b2_q;
  assign instr_b3    = b3_q;
  assign instr_len   = len_q;
  assign instr_pc    = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a registered byte-wide memory model.
module tb_instr_fetch_unit;
  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_strobe;
  logic [7:0]        mem_data = 8'h00;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [7:0]        instr_op, instr_b2, instr_b3;
  logic [1:0]        instr_len;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;

  logic [7:0] mem [256];
  int unsigned checks = 0;
  int unsigned passed = 0;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_strobe(mem_strobe), .mem_data(mem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_b2(instr_b2), .instr_b3(instr_b3),
    .instr_len(instr_len), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data appears the cycle after the strobe.
  always @(posedge clk) if (mem_strobe) mem_data <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_strobe(input string tag, input logic [31:0] strobe, input logic [31:0] addr);
    check({tag, ".strobe"}, 32'(mem_strobe), strobe);
    check({tag, ".addr"}, 32'(mem_addr), addr);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 32'(instr_valid), 32'h0);
  endtask

  task automatic check_bundle(input string tag, input logic [31:0] op, input logic [31:0] b2,
                              input logic [31:0] b3, input logic [31:0] len, input logic [31:0] pc);
    check({tag, ".valid"}, 32'(instr_valid), 32'h1);
    check({tag, ".op"}, 32'(instr_op), op);
    check({tag, ".b2"}, 32'(instr_b2), b2);
    check({tag, ".b3"}, 32'(instr_b3), b3);
    check({tag, ".len"}, 32'(instr_len), len);
    check({tag, ".pc"}, 32'(instr_pc), pc);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".valid"}, 32'(instr_valid), 32'h0);
    check({tag, ".op"}, 32'(instr_op), 32'h0);
    check({tag, ".b2"}, 32'(instr_b2), 32'h0);
    check({tag, ".b3"}, 32'(instr_b3), 32'h0);
    check({tag, ".len"}, 32'(instr_len), 32'h0);
    check({tag, ".pc"}, 32'(instr_pc), 32'h0);
    check_strobe(tag, 32'h0, 32'h0);
  endtask

  // Hold reset two cycles, then release; returns in cycle 0 (S_REQ).
  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    tick();
    check_reset(tag);
    reset = 1'b0;
    settle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // 2-byte instruction from reset
    mem[8'h00] = 8'h0C; mem[8'h01] = 8'h55;
    instr_ready = 1'b1;
    do_reset("t1.rst");
    check_strobe("t1.c0", 32'h1, 32'h00);
    tick(); check_strobe("t1.c1", 32'h1, 32'h01); check_idle("t1.c1");
    tick(); check_strobe("t1.c2", 32'h0, 32'h02); check_idle("t1.c2");
    tick(); check_bundle("t1", 32'h0C, 32'h55, 32'h00, 32'h2, 32'h00);

    // 3-byte then 1-byte back to back
    mem[8'h00] = 8'h8D; mem[8'h01] = 8'h12; mem[8'h02] = 8'h34;
    mem[8'h03] = 8'hFF; mem[8'h04] = 8'h0E;
    do_reset("t2.rst");
    tick(); tick(); tick(); check_idle("t2.c3");
    tick(); check_bundle("t2.a", 32'h8D, 32'h12, 32'h34, 32'h3, 32'h00);
    check_strobe("t2.acc", 32'h1, 32'h03);
    tick(); check_strobe("t2.c5", 32'h0, 32'h04); check_idle("t2.c5");
    tick(); check_bundle("t2.b", 32'hFF, 32'h00, 32'h00, 32'h1, 32'h03);

    // Back-pressure: bundle held, no reads
    instr_ready = 1'b0;
    settle(); check_strobe("t3.hold", 32'h0, 32'h04);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_bundle("t3.held", 32'hFF, 32'h00, 32'h00, 32'h1, 32'h03);
      check_strobe("t3.held", 32'h0, 32'h04);
    end
    instr_ready = 1'b1;
    settle(); check_strobe("t3.rel", 32'h1, 32'h04);
    tick(); check_strobe("t3.cap", 32'h0, 32'h05); check_idle("t3.cap");
    tick(); check_bundle("t3.next", 32'h0E, 32'h00, 32'h00, 32'h1, 32'h04);

    // Redirect in CAP2 of a 3-byte op, twice in a row (last wins)
    mem[8'h00] = 8'h8D; mem[8'h01] = 8'hAA; mem[8'h02] = 8'hBB;
    mem[8'h20] = 8'h0E; mem[8'h40] = 8'h0C; mem[8'h41] = 8'h77;
    mem[8'hFE] = 8'h05; mem[8'hFF] = 8'hA1;
    do_reset("t4.rst");
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 8'h20;
    settle(); check_strobe("t4.rd1", 32'h0, 32'h02);
    tick();
    redirect_pc = 8'h40;
    settle(); check_idle("t4.rd2"); check_strobe("t4.rd2", 32'h0, 32'h20);
    tick();
    redirect_valid = 1'b0;
    settle(); check_idle("t4.req"); check_strobe("t4.req", 32'h1, 32'h40);
    tick(); check_idle("t4.c1"); check_strobe("t4.c1", 32'h1, 32'h41);
    tick(); check_idle("t4.c2"); check_strobe("t4.c2", 32'h0, 32'h42);
    tick(); check_bundle("t4", 32'h0C, 32'h77, 32'h00, 32'h2, 32'h40);

    // Redirect together with accept, then 3-byte op wrapping at 0xFE
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    mem[8'h00] = 8'hC3; mem[8'h01] = 8'h0F;
    settle(); check_strobe("t5.rd", 32'h0, 32'h42);
    tick();
    redirect_valid = 1'b0;
    settle(); check_idle("t5.flush"); check_strobe("t5.fe", 32'h1, 32'hFE);
    tick(); check_strobe("t5.ff", 32'h1, 32'hFF);
    tick(); check_strobe("t5.00", 32'h1, 32'h00);
    tick(); check_strobe("t5.cap3", 32'h0, 32'h01); check_idle("t5.cap3");
    tick(); check_bundle("t5", 32'h05, 32'hA1, 32'hC3, 32'h3, 32'hFE);
    check_strobe("t5.next", 32'h1, 32'h01);

    // Reset asserted in CAP3 drops partial bytes
    mem[8'h00] = 8'h8D; mem[8'h01] = 8'h11; mem[8'h02] = 8'h22;
    do_reset("t6.rst0");
    tick(); tick(); tick();
    reset = 1'b1;
    settle(); check_strobe("t6.rst", 32'h0, 32'h03);
    mem[8'h00] = 8'h0C; mem[8'h01] = 8'h5A;
    tick(); check_reset("t6.mid");
    reset = 1'b0;
    settle(); check_strobe("t6.c0", 32'h1, 32'h00);
    tick();
    tick(); check_idle("t6.c2");
    tick(); check_bundle("t6", 32'h0C, 32'h5A, 32'h00, 32'h2, 32'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
